// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_ctrl_pkg;

   // Encoding is visible on state_o for debug, so values are fixed.
   typedef enum logic [1:0] {
      HZ_RUN        = 2'd0,
      HZ_LOAD_STALL = 2'd1,
      HZ_FLUSH      = 2'd2,
      HZ_MEM_WAIT   = 2'd3
   } hazard_state_e;

   // Architectural zero register; never the source of a dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Free-running 32-bit event counter with enable; wraps modulo 2^32.
module perf_counter (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic [31:0] cnt_o
);

   // Count one per enabled cycle.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_o <= '0;
      else if (en_i) cnt_o <= cnt_o + 32'd1;
   end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: load-use bubbles, taken-branch
// flushes and data-memory wait freezes. Optional performance counters are
// built only when HAZARD_PERF_CNT_EN is defined.
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned BRANCH_PENALTY = 1,
   parameter int unsigned MEM_TIMEOUT    = 15
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        id_valid_i,
   input  logic [4:0]  id_sel_rs1_i,
   input  logic [4:0]  id_sel_rs2_i,
   input  logic        id_uses_rs1_i,
   input  logic        id_uses_rs2_i,
   input  logic        ex_valid_i,
   input  logic        ex_is_load_i,
   input  logic [4:0]  ex_sel_rd_i,
   input  logic        ex_branch_taken_i,
   input  logic        mem_req_i,
   input  logic        mem_ready_i,
   output logic        pc_stall_o,
   output logic        if_id_stall_o,
   output logic        if_id_flush_o,
   output logic        id_ex_flush_o,
   output logic        ex_mem_stall_o,
   output logic        mem_wb_flush_o,
   output logic [1:0]  state_o,
   output logic        timeout_err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   // Extra flush cycles after the branch cycle itself.
   localparam logic [2:0] FLUSH_RELOAD = 3'(BRANCH_PENALTY - 1);
   localparam logic [7:0] TIMEOUT_LIM  = 8'(MEM_TIMEOUT);

   hazard_state_e state_q, state_d;
   logic [2:0]    flush_left_q, flush_left_d;
   logic [7:0]    wait_cnt_q, wait_cnt_d;
   logic          timeout_q, timeout_d;

   logic mem_wait;
   logic branch_taken;
   logic load_use;

   assign mem_wait     = mem_req_i & ~mem_ready_i;
   assign branch_taken = ex_branch_taken_i & ex_valid_i;
   assign load_use     = ex_valid_i & ex_is_load_i & (ex_sel_rd_i != REG_ZERO) & id_valid_i &
                         ((id_uses_rs1_i & (id_sel_rs1_i == ex_sel_rd_i)) |
                          (id_uses_rs2_i & (id_sel_rs2_i == ex_sel_rd_i)));

   // Next-state and control outputs: memory wait, then branch, then state-specific rules.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
      pc_stall_o     = 1'b0;
      if_id_stall_o  = 1'b0;
      if_id_flush_o  = 1'b0;
      id_ex_flush_o  = 1'b0;
      ex_mem_stall_o = 1'b0;
      mem_wb_flush_o = 1'b0;
      state_d        = state_q;
      flush_left_d   = flush_left_q;
      wait_cnt_d     = '0;
      timeout_d      = timeout_q;

      if (mem_wait) begin
         // Freeze the pipe; a branch in EX is held until the access completes.
         pc_stall_o     = 1'b1;
         if_id_stall_o  = 1'b1;
         ex_mem_stall_o = 1'b1;
         mem_wb_flush_o = 1'b1;
         state_d        = HZ_MEM_WAIT;
         wait_cnt_d     = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
         if (wait_cnt_d >= TIMEOUT_LIM) timeout_d = 1'b1;
      end else if (branch_taken) begin
         // Wrong-path instructions in IF/ID and ID/EX are discarded.
         if_id_flush_o = 1'b1;
         id_ex_flush_o = 1'b1;
         if (BRANCH_PENALTY > 1) begin
            state_d      = HZ_FLUSH;
            flush_left_d = FLUSH_RELOAD;
         end else begin
            state_d = HZ_RUN;
         end
      end else begin
         case (state_q)
            HZ_FLUSH: begin
               if_id_flush_o = 1'b1;
               if (flush_left_q <= 3'd1) begin
                  flush_left_d = '0;
                  state_d      = HZ_RUN;
               end else begin
                  flush_left_d = flush_left_q - 3'd1;
               end
            end
            // EX now holds the bubble, so the pair cannot collide again.
            HZ_LOAD_STALL: state_d = HZ_RUN;
            // RUN, and MEM_WAIT on the cycle the access completes.
            default: begin
               if (load_use) begin
                  pc_stall_o    = 1'b1;
                  if_id_stall_o = 1'b1;
                  id_ex_flush_o = 1'b1;
                  state_d       = HZ_LOAD_STALL;
               end else begin
                  state_d = HZ_RUN;
               end
            end
         endcase
      end
   end

   // State, flush countdown, wait counter and sticky timeout flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_ni) begin
         state_q      <= HZ_RUN;
         flush_left_q <= '0;
         wait_cnt_q   <= '0;
         timeout_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         flush_left_q <= flush_left_d;
         wait_cnt_q   <= wait_cnt_d;
         timeout_q    <= timeout_d;
      end
   end

   assign state_o       = state_q;
   assign timeout_err_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
   perf_counter u_stall_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (pc_stall_o),
      .cnt_o  (stall_cnt_o)
   );

   perf_counter u_flush_cnt (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .en_i   (if_id_flush_o),
      .cnt_o  (flush_cnt_o)
   );
`else
   assign stall_cnt_o = '0;
   assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl (BRANCH_PENALTY=3, MEM_TIMEOUT=3): directed table,
// hand-written multi-cycle sequences and a randomized run against a model.
module tb_hazard_ctrl;

   localparam int unsigned BP = 3;
   localparam int unsigned MT = 3;
`ifdef HAZARD_PERF_CNT_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   typedef struct packed {
      logic       idv;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic       exv;
      logic       ld;
      logic [4:0] rd;
      logic       br;
      logic       req;
      logic       rdy;
   } stim_t;

   // ctrl = {pc_stall, if_id_stall, if_id_flush, id_ex_flush, ex_mem_stall, mem_wb_flush}
   typedef struct packed {
      logic [5:0] ctrl;
      logic [1:0] state;
      logic       err;
   } resp_t;

   typedef struct {
      stim_t s;
      resp_t r;
   } vec_t;

   localparam logic [5:0] C_NONE  = 6'b000000;
   localparam logic [5:0] C_WAIT  = 6'b110011;
   localparam logic [5:0] C_LU    = 6'b110100;
   localparam logic [5:0] C_BR    = 6'b001100;
   localparam logic [5:0] C_FLUSH = 6'b001000;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        id_valid_i, id_uses_rs1_i, id_uses_rs2_i;
   logic [4:0]  id_sel_rs1_i, id_sel_rs2_i, ex_sel_rd_i;
   logic        ex_valid_i, ex_is_load_i, ex_branch_taken_i, mem_req_i, mem_ready_i;
   logic        pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o;
   logic        ex_mem_stall_o, mem_wb_flush_o, timeout_err_o;
   logic [1:0]  state_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;

   int n_checks = 0;
   int n_pass   = 0;

   hazard_ctrl #(.BRANCH_PENALTY(BP), .MEM_TIMEOUT(MT)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .id_valid_i        (id_valid_i),
      .id_sel_rs1_i      (id_sel_rs1_i),
      .id_sel_rs2_i      (id_sel_rs2_i),
      .id_uses_rs1_i     (id_uses_rs1_i),
      .id_uses_rs2_i     (id_uses_rs2_i),
      .ex_valid_i        (ex_valid_i),
      .ex_is_load_i      (ex_is_load_i),
      .ex_sel_rd_i       (ex_sel_rd_i),
      .ex_branch_taken_i (ex_branch_taken_i),
      .mem_req_i         (mem_req_i),
      .mem_ready_i       (mem_ready_i),
      .pc_stall_o        (pc_stall_o),
      .if_id_stall_o     (if_id_stall_o),
      .if_id_flush_o     (if_id_flush_o),
      .id_ex_flush_o     (id_ex_flush_o),
      .ex_mem_stall_o    (ex_mem_stall_o),
      .mem_wb_flush_o    (mem_wb_flush_o),
      .state_o           (state_o),
      .timeout_err_o     (timeout_err_o),
      .stall_cnt_o       (stall_cnt_o),
      .flush_cnt_o       (flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic stim_t st(input bit idv, input int rs1, input bit u1, input int rs2,
                                input bit u2, input bit exv, input bit ld, input int rd,
                                input bit br, input bit req, input bit rdy);
      stim_t s;
      s.idv = idv; s.rs1 = 5'(rs1); s.u1 = u1; s.rs2 = 5'(rs2); s.u2 = u2;
      s.exv = exv; s.ld = ld; s.rd = 5'(rd); s.br = br; s.req = req; s.rdy = rdy;
      return s;
   endfunction

   function automatic resp_t rs(input logic [5:0] ctrl, input int state, input bit err);
      resp_t r;
      r.ctrl = ctrl; r.state = 2'(state); r.err = err;
      return r;
   endfunction

   task automatic drive(input stim_t s);
      id_valid_i = s.idv;   id_sel_rs1_i = s.rs1; id_uses_rs1_i = s.u1;
      id_sel_rs2_i = s.rs2; id_uses_rs2_i = s.u2;
      ex_valid_i = s.exv;   ex_is_load_i = s.ld;  ex_sel_rd_i = s.rd;
      ex_branch_taken_i = s.br; mem_req_i = s.req; mem_ready_i = s.rdy;
   endtask

   function automatic resp_t observe();
      resp_t r;
      r.ctrl  = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, ex_mem_stall_o, mem_wb_flush_o};
      r.state = state_o;
      r.err   = timeout_err_o;
      return r;
   endfunction

   // Drive one cycle, check outputs mid-cycle, then let the clock edge pass.
   task automatic apply(input stim_t s, input resp_t r, input string name);
      drive(s);
      #2;
      check(name, 64'(observe()), 64'(r));
      @(posedge clk_i);
      #1;
   endtask

   // Asynchronous reset asserted mid-cycle with idle inputs.
   task automatic do_reset(input string name);
      drive(st(0,0,0,0,0,0,0,0,0,0,0));
      #1;
      rst_ni = 1'b0;
      #1;
      check(name, 64'(observe()), 64'(rs(C_NONE, 0, 0)));
      @(posedge clk_i);
      #2;
      rst_ni = 1'b1;
   endtask

   // Reference model: remaining flush cycles, pending bubble, wait tracking.
   int          m_flush_left;
   bit          m_bubble, m_waiting, m_err;
   int          m_wait_cycles;
   int unsigned m_stalls, m_flushes;

   function automatic void model_reset();
      m_flush_left = 0; m_bubble = 0; m_waiting = 0; m_err = 0;
      m_wait_cycles = 0; m_stalls = 0; m_flushes = 0;
   endfunction

   function automatic bit is_load_use(input stim_t s);
      return s.exv && s.ld && (s.rd != 0) && s.idv &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
   endfunction

   function automatic resp_t model_expect(input stim_t s);
      resp_t r;
      r = '0;
      if (m_waiting) r.state = 2'd3;
      else if (m_flush_left > 0) r.state = 2'd2;
      else if (m_bubble) r.state = 2'd1;
      if (s.req && !s.rdy) r.ctrl = C_WAIT;
      else if (s.br && s.exv) r.ctrl = C_BR;
      else if (m_flush_left > 0) r.ctrl = C_FLUSH;
      else if (!m_bubble && is_load_use(s)) r.ctrl = C_LU;
      r.err = m_err;
      return r;
   endfunction

   function automatic void model_step(input stim_t s);
      resp_t r;
      r = model_expect(s);
      m_stalls  += 32'(r.ctrl[5]);
      m_flushes += 32'(r.ctrl[3]);
      if (s.req && !s.rdy) begin
         m_waiting = 1; m_flush_left = 0; m_bubble = 0;
         if (m_wait_cycles < 255) m_wait_cycles++;
         if (m_wait_cycles >= int'(MT)) m_err = 1;
      end else begin
         m_waiting = 0; m_wait_cycles = 0;
         if (s.br && s.exv) begin
            m_flush_left = int'(BP) - 1; m_bubble = 0;
         end else if (m_flush_left > 0) begin
            m_flush_left--;
         end else if (m_bubble) begin
            m_bubble = 0;
         end else if (is_load_use(s)) begin
            m_bubble = 1;
         end
      end
   endfunction

   vec_t  tbl[17];
   stim_t idle, lu5, brk, wait_br, wait_s, ready_s;

   initial begin
      idle    = st(0,0,0,0,0,0,0,0,0,0,0);
      lu5     = st(1,5,1,0,0,1,1,5,0,0,0);
      brk     = st(0,0,0,0,0,1,0,0,1,0,0);
      wait_br = st(0,0,0,0,0,1,0,0,1,1,0);
      wait_s  = st(0,0,0,0,0,0,0,0,0,1,0);
      ready_s = st(0,0,0,0,0,0,0,0,0,1,1);

      tbl[0]  = '{idle, rs(C_NONE, 0, 0)};
      tbl[1]  = '{lu5, rs(C_LU, 0, 0)};
      tbl[2]  = '{lu5, rs(C_NONE, 1, 0)};
      tbl[3]  = '{idle, rs(C_NONE, 0, 0)};
      tbl[4]  = '{st(1,0,1,0,0,1,1,0,0,0,0), rs(C_NONE, 0, 0)};
      tbl[5]  = '{st(1,3,1,7,0,1,1,7,0,0,0), rs(C_NONE, 0, 0)};
      tbl[6]  = '{st(1,3,1,7,1,1,1,7,0,0,0), rs(C_LU, 0, 0)};
      tbl[7]  = '{idle, rs(C_NONE, 1, 0)};
      tbl[8]  = '{brk, rs(C_BR, 0, 0)};
      tbl[9]  = '{lu5, rs(C_FLUSH, 2, 0)};
      tbl[10] = '{lu5, rs(C_FLUSH, 2, 0)};
      tbl[11] = '{idle, rs(C_NONE, 0, 0)};
      tbl[12] = '{st(0,0,0,0,0,0,0,0,1,0,0), rs(C_NONE, 0, 0)};
      tbl[13] = '{st(1,5,1,0,0,1,1,5,1,0,0), rs(C_BR, 0, 0)};
      tbl[14] = '{idle, rs(C_FLUSH, 2, 0)};
      tbl[15] = '{idle, rs(C_FLUSH, 2, 0)};
      tbl[16] = '{idle, rs(C_NONE, 0, 0)};

      drive(idle);
      #12;
      check("reset_stall_cnt", 64'(stall_cnt_o), 64'd0);
      check("reset_flush_cnt", 64'(flush_cnt_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      for (int i = 0; i < 17; i++) apply(tbl[i].s, tbl[i].r, $sformatf("table[%0d]", i));
      #2;
      check("perf_stall_after_table", 64'(stall_cnt_o), PERF ? 64'd2 : 64'd0);
      check("perf_flush_after_table", 64'(flush_cnt_o), PERF ? 64'd6 : 64'd0);
      @(posedge clk_i);
      #1;

      // Memory wait with a held branch: flush only on the ready cycle.
      do_reset("reset_before_wait");
      apply(wait_br, rs(C_WAIT, 0, 0), "wait_c1");
      apply(wait_br, rs(C_WAIT, 3, 0), "wait_c2");
      apply(wait_br, rs(C_WAIT, 3, 0), "wait_c3");
      apply(wait_br, rs(C_WAIT, 3, 1), "wait_c4");
      apply(st(0,0,0,0,0,1,0,0,1,1,1), rs(C_BR, 3, 1), "wait_ready_branch");
      apply(idle, rs(C_FLUSH, 2, 1), "wait_post_flush1");
      apply(idle, rs(C_FLUSH, 2, 1), "wait_post_flush2");
      apply(idle, rs(C_NONE, 0, 1), "wait_back_run");

      // Timeout: 5 wait cycles, error rises after the 3rd and is sticky.
      do_reset("reset_before_timeout");
      apply(wait_s, rs(C_WAIT, 0, 0), "to_c1");
      apply(wait_s, rs(C_WAIT, 3, 0), "to_c2");
      apply(wait_s, rs(C_WAIT, 3, 0), "to_c3");
      apply(wait_s, rs(C_WAIT, 3, 1), "to_c4");
      apply(wait_s, rs(C_WAIT, 3, 1), "to_c5");
      apply(ready_s, rs(C_NONE, 3, 1), "to_ready");
      apply(idle, rs(C_NONE, 0, 1), "to_sticky");
      apply(wait_s, rs(C_WAIT, 0, 1), "to_enter_wait");
      do_reset("reset_in_mem_wait");

      // Reset while in FLUSH.
      apply(brk, rs(C_BR, 0, 0), "flush_enter");
      apply(idle, rs(C_FLUSH, 2, 0), "flush_active");
      do_reset("reset_in_flush");
      #2;
      check("perf_stall_after_reset", 64'(stall_cnt_o), 64'd0);
      check("perf_flush_after_reset", 64'(flush_cnt_o), 64'd0);

      // Randomized run against the reference model.
      model_reset();
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 600; i++) begin
         stim_t s;
         resp_t r;
         bit    req;
         if ($urandom_range(0, 79) == 0) begin
            do_reset("rand_reset");
            model_reset();
            continue;
         end
         req = ($urandom_range(0, 4) == 0);
         s = st($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
                $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 1), $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
                req, req ? $urandom_range(0, 1) : 1'b0);
         drive(s);
         #2;
         r = model_expect(s);
         check($sformatf("rand[%0d]", i), 64'(observe()), 64'(r));
         check($sformatf("rand_stall_cnt[%0d]", i), 64'(stall_cnt_o), PERF ? 64'(m_stalls) : 64'd0);
         check($sformatf("rand_flush_cnt[%0d]", i), 64'(flush_cnt_o), PERF ? 64'(m_flushes) : 64'd0);
         @(posedge clk_i);
         model_step(s);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
